// File: rtl/huffman_encode_arbiter.sv
// Round-robin front end for a single HuffmanEncode core: two block producers share the
// encoder, each granted block is cleared, started, awaited (with timeout) and held for the packer.
module huffman_encode_arbiter #(
   parameter int TIMEOUT = 200
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid0,
   input  logic         req_valid1,
   output logic         req_ready0,
   output logic         req_ready1,
   input  logic [767:0] req_blk0,
   input  logic [767:0] req_blk1,
   output logic         enc_reset,
   output logic         enc_start,
   output logic [767:0] enc_blk,
   input  logic         enc_done,
   input  logic [511:0] enc_data,
   input  logic [8:0]   enc_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] out_data,
   output logic [8:0]   out_bits,
   output logic         out_src,
   output logic         out_timeout,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic           grant0_s;
   logic           grant1_s;
   logic           expire_s;
   logic           last_r;
   logic           src_r;
   logic [7:0]     cnt_r;
   logic [767:0]   blk_r;
   logic [511:0]   out_data_r;
   logic [8:0]     out_bits_r;
   logic           out_timeout_r;
   logic           out_valid_r;
   logic           busy_r;
   logic           enc_start_r;

   // Next-state and grant decode; the requester that did not win last time has priority on a tie.
   always_comb begin
      state_s  = state_r;
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      expire_s = (cnt_r == 8'(TIMEOUT - 1));
      case (state_r)
         IDLE: begin
            if (req_valid0 && (!req_valid1 || last_r)) begin
               grant0_s = 1'b1;
               state_s  = CLR;
            end else if (req_valid1) begin
               grant1_s = 1'b1;
               state_s  = CLR;
            end else begin
               state_s  = IDLE;
            end
         end
         CLR: begin
            state_s = RUN;
         end
         RUN: begin
            if (enc_done) begin
               state_s = HOLD;
            end else if (expire_s) begin
               state_s = HOLD;
            end else begin
               state_s = RUN;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Grant strobes are masked during reset so no block is offered as accepted while it is discarded.
   always_comb begin
      req_ready0 = grant0_s & ~reset;
      req_ready1 = grant1_s & ~reset;
      enc_reset  = reset | (state_r == CLR);
   end

   // State, captured block, cycle counter and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         last_r        <= 1'b1;
         src_r         <= 1'b0;
         cnt_r         <= 8'd0;
         blk_r         <= 768'd0;
         out_data_r    <= 512'd0;
         out_bits_r    <= 9'd0;
         out_timeout_r <= 1'b0;
         out_valid_r   <= 1'b0;
         busy_r        <= 1'b0;
         enc_start_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         out_valid_r <= (state_s == HOLD);
         busy_r      <= (state_s != IDLE);
         enc_start_r <= (state_s == RUN);

         if (grant0_s || grant1_s) begin
            blk_r <= grant1_s ? req_blk1 : req_blk0;
            src_r <= grant1_s;
         end

         if (state_r == CLR) begin
            cnt_r <= 8'd0;
         end else if (state_r == RUN) begin
            cnt_r <= cnt_r + 8'd1;
         end

         // A done in the same cycle as the timeout still delivers the real result.
         if (state_r == RUN) begin
            if (enc_done) begin
               out_data_r    <= enc_data;
               out_bits_r    <= enc_bits;
               out_timeout_r <= 1'b0;
            end else if (expire_s) begin
               out_data_r    <= 512'd0;
               out_bits_r    <= 9'd0;
               out_timeout_r <= 1'b1;
            end
         end

         if ((state_r == HOLD) && out_ready) begin
            last_r <= src_r;
         end
      end
   end

   assign enc_start   = enc_start_r;
   assign enc_blk     = blk_r;
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign out_bits    = out_bits_r;
   assign out_src     = src_r;
   assign out_timeout = out_timeout_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_huffman_encode_arbiter.sv
// Directed bench for huffman_encode_arbiter: a scripted encoder stub plus a result scoreboard.
module tb_huffman_encode_arbiter;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid0, req_valid1;
   logic         req_ready0, req_ready1;
   logic [767:0] req_blk0, req_blk1;
   logic         enc_reset, enc_start;
   logic [767:0] enc_blk;
   logic         enc_done;
   logic [511:0] enc_data;
   logic [8:0]   enc_bits;
   logic         out_valid, out_ready;
   logic [511:0] out_data;
   logic [8:0]   out_bits;
   logic         out_src, out_timeout, busy;

   typedef struct {
      logic [511:0] data;
      logic [8:0]   bits;
      logic         src;
      logic         to;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   huffman_encode_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid0(req_valid0), .req_valid1(req_valid1),
      .req_ready0(req_ready0), .req_ready1(req_ready1),
      .req_blk0(req_blk0), .req_blk1(req_blk1),
      .enc_reset(enc_reset), .enc_start(enc_start), .enc_blk(enc_blk),
      .enc_done(enc_done), .enc_data(enc_data), .enc_bits(enc_bits),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_bits(out_bits), .out_src(out_src),
      .out_timeout(out_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [767:0] rnd_blk();
      logic [767:0] r;
      for (int i = 0; i < 24; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] rnd_data();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".sb_nonempty"}, (sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, ".data"}, out_data, e.data);
         chk({tag, ".bits"}, out_bits, e.bits);
         chk({tag, ".src"}, out_src, e.src);
         chk({tag, ".timeout"}, out_timeout, e.to);
      end
   endtask

   // Waits for a grant, then steps the block through CLR and RUN; done_k < 0 means no done (timeout).
   task automatic accept_run(input logic exp_src, input int done_k, input logic [511:0] d,
                             input logic [8:0] b, input string tag);
      logic [767:0] eb;
      exp_t         e;
      bit           got;
      got      = 1'b0;
      enc_done = 1'b1;
      enc_data = rnd_data();
      enc_bits = 9'h1FF;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req_ready0 || req_ready1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, ".accept_seen"}, got, 1'b1);
      chk({tag, ".ready0"}, req_ready0, !exp_src);
      chk({tag, ".ready1"}, req_ready1, exp_src);
      chk({tag, ".idle_valid"}, out_valid, 1'b0);
      chk({tag, ".idle_enc_reset"}, enc_reset, 1'b0);
      eb     = exp_src ? req_blk1 : req_blk0;
      e.data = (done_k < 0) ? 512'd0 : d;
      e.bits = (done_k < 0) ? 9'd0 : b;
      e.src  = exp_src;
      e.to   = (done_k < 0);
      sb.push_back(e);
      tick();
      req_blk0 = rnd_blk();
      req_blk1 = rnd_blk();
      #1;
      chk({tag, ".clr_enc_reset"}, enc_reset, 1'b1);
      chk({tag, ".clr_enc_start"}, enc_start, 1'b0);
      chk({tag, ".clr_busy"}, busy, 1'b1);
      chk({tag, ".clr_ready"}, {req_ready1, req_ready0}, 2'b00);
      chk({tag, ".clr_blk"}, enc_blk, eb);
      tick();
      for (int k = 0; k <= TO; k++) begin
         chk({tag, ".run_start"}, enc_start, 1'b1);
         chk({tag, ".run_enc_reset"}, enc_reset, 1'b0);
         chk({tag, ".run_valid"}, out_valid, 1'b0);
         if (k == done_k) begin
            enc_done = 1'b1;
            enc_data = d;
            enc_bits = b;
         end else begin
            enc_done = 1'b0;
            enc_data = rnd_data();
            enc_bits = 9'($urandom);
         end
         tick();
         if ((k == done_k) || ((done_k < 0) && (k == TO - 1))) break;
      end
      enc_done = 1'b0;
      chk({tag, ".hold_valid"}, out_valid, 1'b1);
      chk({tag, ".hold_start"}, enc_start, 1'b0);
      chk({tag, ".hold_busy"}, busy, 1'b1);
      chk({tag, ".hold_blk"}, enc_blk, eb);
   endtask

   initial begin
      logic [95:0]  row0;
      logic [767:0] blk;
      logic [511:0] d;
      logic [8:0]   b;

      reset      = 1'b1;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      req_blk0   = 768'd0;
      req_blk1   = 768'd0;
      enc_done   = 1'b0;
      enc_data   = 512'd0;
      enc_bits   = 9'd0;
      out_ready  = 1'b0;
      tick();
      tick();
      req_valid0 = 1'b1;
      #1;
      chk("rst.enc_reset", enc_reset, 1'b1);
      chk("rst.ready0", req_ready0, 1'b0);
      chk("rst.busy", busy, 1'b0);
      chk("rst.valid", out_valid, 1'b0);
      chk("rst.start", enc_start, 1'b0);
      chk("rst.outs", {out_data, out_bits, out_src, out_timeout}, 523'd0);
      chk("rst.blk", enc_blk, 768'd0);
      req_valid0 = 1'b0;
      reset      = 1'b0;
      tick();
      chk("rst.enc_reset_low", enc_reset, 1'b0);

      // Single request with the reference row 0 and done 5 cycles into RUN.
      row0 = {12'hFFD, 12'h000, 12'hFF5, 12'h009, 12'h005, 12'h007, 12'hFF8, 12'h004};
      blk  = rnd_blk();
      blk[95:0] = row0;
      req_blk0   = blk;
      req_valid0 = 1'b1;
      d = rnd_data();
      accept_run(1'b0, 5, d, 9'd37, "single");
      chk("single.row0", enc_blk[95:0], row0);
      req_valid0 = 1'b0;
      out_ready  = 1'b1;
      pop_check("single.out");
      tick();
      chk("single.valid_fall", out_valid, 1'b0);
      chk("single.busy_fall", busy, 1'b0);

      // Fresh reset so last=1, then both requesters held valid for four blocks.
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      req_valid0 = 1'b1;
      req_valid1 = 1'b1;
      req_blk0   = rnd_blk();
      req_blk1   = rnd_blk();
      for (int i = 0; i < 4; i++) begin
         d = rnd_data();
         b = 9'(10 + i);
         accept_run(1'(i % 2), 2 + i, d, b, "rr");
         out_ready = 1'b1;
         pop_check("rr.out");
         tick();
      end

      // Backpressure: result held for 10 cycles while both requesters wait.
      out_ready = 1'b0;
      d = rnd_data();
      accept_run(1'b0, 1, d, 9'd200, "bp");
      for (int i = 0; i < 10; i++) begin
         chk("bp.valid", out_valid, 1'b1);
         chk("bp.data", out_data, d);
         chk("bp.bits", out_bits, 9'd200);
         chk("bp.ready", {req_ready1, req_ready0}, 2'b00);
         tick();
      end
      out_ready = 1'b1;
      pop_check("bp.out");
      tick();
      d = rnd_data();
      accept_run(1'b1, 0, d, 9'd511, "bp_next");
      req_valid1 = 1'b0;
      pop_check("bp_next.out");
      tick();

      // Timeout: done never asserted in RUN.
      accept_run(1'b0, -1, rnd_data(), 9'd77, "timeout");
      req_valid0 = 1'b0;
      pop_check("timeout.out");
      tick();

      // Reset on the third RUN cycle aborts the block; last returns to 1.
      req_valid0 = 1'b1;
      #1;
      chk("abort.ready0", req_ready0, 1'b1);
      tick();
      req_valid0 = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("abort.enc_reset", enc_reset, 1'b1);
      chk("abort.run_start", enc_start, 1'b1);
      tick();
      chk("abort.start", enc_start, 1'b0);
      chk("abort.busy", busy, 1'b0);
      chk("abort.valid", out_valid, 1'b0);
      chk("abort.blk", enc_blk, 768'd0);
      reset    = 1'b0;
      enc_done = 1'b1;
      enc_data = rnd_data();
      enc_bits = 9'd99;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort.idle_done_valid", out_valid, 1'b0);
         chk("abort.idle_done_busy", busy, 1'b0);
      end
      enc_done   = 1'b0;
      req_valid0 = 1'b1;
      req_valid1 = 1'b1;
      d = rnd_data();
      accept_run(1'b0, 3, d, 9'd5, "post_reset");
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      pop_check("post_reset.out");
      tick();
      chk("end.valid", out_valid, 1'b0);
      chk("end.sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/huffman_encode_arbiter.md
# huffman_encode_arbiter

Two-requester round-robin arbiter and sequencer for the single HuffmanEncode instance. It accepts complete 8x8 blocks of 12-bit coefficients from two producers (e.g. luma and chroma paths). For each granted block it clears the encoder, starts it, and waits for `done`, with a cycle-count timeout. It then holds the encoded bitstream on a valid/ready output until the downstream packer consumes it.

## Interface
- `TIMEOUT`, 200: maximum RUN cycles before the encode is abandoned (1..255).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid0` / `req_valid1` in 1: requester N has a block.
- `req_ready0` / `req_ready1` out 1: block N accepted this cycle.
- `req_blk0` / `req_blk1` in 768: block rows; row r = bits [96r+95:96r], coefficient c of a row = bits [12(7-c)+11:12(7-c)] within the row.
- `enc_reset` out 1: to encoder `reset`.
- `enc_start` out 1: to encoder `start`.
- `enc_blk` out 768: to encoder `data_in0..7` (row r drives `data_in<r>`).
- `enc_done` in 1: encoder `done`.
- `enc_data` in 512: encoder `data_out`.
- `enc_bits` in 9: encoder `num_bits`.
- `out_valid` out 1; `out_ready` in 1: result handshake.
- `out_data` out 512: encoded bitstream.
- `out_bits` out 9: number of valid bits.
- `out_src` out 1: requester index.
- `out_timeout` out 1: result abandoned.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, CLR, RUN, HOLD. Reset enters IDLE.
- IDLE:
  - Grant when any `req_valid` is high. With one requester, it wins. With both, the requester that is not `last` wins (`last` resets to 1, so req0 wins first).
  - `req_readyN` = (IDLE && grantN), combinational, one cycle only.
  - At that edge: capture `req_blkN` into an internal block register, record src = N, go to CLR.
- CLR: `enc_reset`=1 for exactly one cycle, then go to RUN and clear the cycle counter.
- RUN:
  - `enc_start`=1 continuously; counter increments each cycle.
  - If `enc_done`=1: capture `enc_data`/`enc_bits`, set `out_timeout`=0, go to HOLD.
  - Else, if the counter equals TIMEOUT-1: set `out_data`=0, `out_bits`=0, `out_timeout`=1, go to HOLD.
  - `enc_done` takes priority when both conditions hit in the same cycle.
- HOLD:
  - `out_valid`=1; `out_data`, `out_bits`, `out_src`, `out_timeout` are registered and stable.
  - On `out_ready`=1: set `last`=src, go to IDLE.
- `enc_start`=0 in IDLE, CLR and HOLD.
- `enc_done` is ignored outside RUN.
- `enc_blk` always drives the internal block register, which is stable from CLR through HOLD.
- `enc_reset` = `reset` OR (state==CLR), so system reset also clears the encoder.
- `req_valid` is ignored outside IDLE; there is no queuing.

## Timing
- Reset values: state IDLE; `last`=1; `req_ready*`=0; `enc_start`=0; `enc_reset`=1 during reset; `out_valid`=0; `out_data`=0; `out_bits`=0; `out_src`=0; `out_timeout`=0; `busy`=0; block register=0.
- Accept edge at cycle T: CLR in T+1, RUN from T+2.
- If `enc_done` is first sampled high at cycle T+2+k (k≥0), `out_valid` rises at T+3+k. Minimum accept-to-valid latency is 3 cycles.
- Timeout: `out_valid` rises at T+2+TIMEOUT.
- `out_valid` falls on the cycle after the `out_ready` handshake. The next request can be accepted in that same cycle, since it is IDLE.
- Minimum accept-to-accept interval is 4 cycles.
- Reset mid-operation (any state): next cycle is IDLE with reset values. Any captured result is discarded, and no `out_valid` is produced for the aborted block.

## Test plan
- Single request: `req_valid0`=1 with row0 = {FFD,000,FF5,009,005,007,FF8,004}; stub `enc_done` 5 cycles into RUN with `enc_bits`=9'd37. Required: `req_ready0` pulses once; `enc_reset` pulses 1 cycle; `enc_start` held 6 cycles; `out_valid` at accept+8 with `out_bits`=37, `out_src`=0, `out_timeout`=0; row0 seen unchanged on `enc_blk`[95:0].
- Both requesters held valid for 4 blocks with `out_ready`=1: grant order is 0,1,0,1; `out_src` sequence is 0,1,0,1.
- Backpressure: `out_ready`=0 for 10 cycles in HOLD. Required: `out_valid` stays 1; data/bits constant; `req_ready*`=0 despite valid requests; a single accept occurs after `out_ready` rises.
- Timeout with TIMEOUT=8 and `enc_done` never asserted: `out_valid` at accept+10 with `out_timeout`=1, `out_bits`=0, `out_data`=0.
- `reset` pulsed on the 3rd RUN cycle: `enc_start`=0 and `busy`=0 the next cycle; `enc_reset` high during reset; no `out_valid`; next request granted to req0.
- `enc_done`=1 while IDLE or CLR: ignored; the result is captured only on the first `enc_done` in RUN.
